// File: rtl/mat_pkg.sv
// Shared definitions for the 2x2 matrix multiplier blocks.
// Contents: element and stream constants, the serializer state type, the
// row/column-major output order tables, and an even-parity helper.
package mat_pkg;

    localparam int unsigned IN_W   = 8;
    localparam int unsigned DW     = 2 * IN_W + 1;
    localparam int unsigned N_ELEM = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Stream position -> element index (0=c_11, 1=c_12, 2=c_21, 3=c_22),
    // packed two bits per position with position 0 in the low bits.
    localparam logic [2*N_ELEM-1:0] ROW_ORDER = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [2*N_ELEM-1:0] COL_ORDER = {2'd3, 2'd1, 2'd2, 2'd0};

    function automatic logic [IDX_W-1:0] elem_sel(input logic col_major,
                                                  input logic [IDX_W-1:0] pos);
        logic [2*N_ELEM-1:0] tbl;
        tbl = col_major ? COL_ORDER : ROW_ORDER;
        return tbl[{pos, 1'b0} +: IDX_W];
    endfunction

    function automatic logic parity(input logic [DW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mat_result_serializer_if.sv
// Load and stream handshake bundle of mat_result_serializer.
//   slave : the serializer's view (accepts result sets, drives the stream)
//   master: the environment's view (supplies result sets, consumes the stream)
// With OUT_PARITY_EN defined the stream carries out_par as well.
interface mat_result_serializer_if;
    import mat_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              col_major;
    logic [DW-1:0]     c_11;
    logic [DW-1:0]     c_12;
    logic [DW-1:0]     c_21;
    logic [DW-1:0]     c_22;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
`ifdef OUT_PARITY_EN
    logic              out_par;
`endif

    modport slave (
        input  in_valid, col_major, c_11, c_12, c_21, c_22, out_ready,
`ifdef OUT_PARITY_EN
        output out_par,
`endif
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, col_major, c_11, c_12, c_21, c_22, out_ready,
`ifdef OUT_PARITY_EN
        input  out_par,
`endif
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/mat_result_serializer.sv
// Captures one 2x2 result set and streams its four elements one per
// handshake, in row- or column-major order, with index and last flag.
// Ports: clk, rst (async, active high), bus (mat_result_serializer_if.slave),
//        mat_count (drained-set counter, wraps).
// Optional: OUT_PARITY_EN adds the registered even-parity output bus.out_par.
module mat_result_serializer
    import mat_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mat_result_serializer_if.slave bus,
    output logic [CNT_W-1:0]       mat_count
);

    state_e                     state_q, state_d;
    logic [N_ELEM-1:0][DW-1:0]  cap_q, cap_d;
    logic                       col_q, col_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DW-1:0]              data_q, data_d;
    logic                       last_q, last_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
`ifdef OUT_PARITY_EN
    logic                       par_q, par_d;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        col_d   = col_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SEND;
                    cap_d   = {bus.c_22, bus.c_21, bus.c_12, bus.c_11};
                    col_d   = bus.col_major;
                    idx_d   = '0;
                    // Position 0 is c_11 in both orders.
                    data_d  = bus.c_11;
                    last_d  = 1'b0;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        data_d  = cap_q[elem_sel(col_q, idx_d)];
                        last_d  = (idx_d == IDX_W'(N_ELEM - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef OUT_PARITY_EN
        par_d = parity(data_d);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cap_q   <= '0;
            col_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef OUT_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`ifdef OUT_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
`ifdef OUT_PARITY_EN
    assign bus.out_par   = par_q;
`endif
    assign mat_count     = cnt_q;

endmodule

// File: tb/tb_mat_result_serializer.sv
// Directed scoreboard bench for mat_result_serializer: a 16-bit counter
// instance for the stream tests and a 2-bit counter instance for wrap.
module tb_mat_result_serializer;
    import mat_pkg::*;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mat_count;
    logic [1:0]  mat_count_w;

    mat_result_serializer_if bus ();
    mat_result_serializer_if bus_w ();

    mat_result_serializer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .mat_count(mat_count)
    );
    mat_result_serializer #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w), .mat_count(mat_count_w)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_xfer  = 0;
    int   last_xfer_cyc = 0;
    int   accept_cyc    = 0;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every transfer on the main stream pops one expected element.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_xfer", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e.data));
                chk("out_idx",  32'(bus.out_idx),  32'(e.idx));
                chk("out_last", 32'(bus.out_last), 32'(e.last));
`ifdef OUT_PARITY_EN
                chk("out_par",  32'(bus.out_par),  32'(^e.data));
`endif
                n_xfer++;
                if (bus.out_last) last_xfer_cyc = cyc + 1;
            end
        end
    end

    task automatic load(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                        input logic cm, input bit hold);
        logic [DW-1:0] arr [4];
        int            ord [4];
        bit            accepted;
        exp_t          e;
        arr = '{d0, d1, d2, d3};
        if (cm) ord = '{0, 2, 1, 3};
        else    ord = '{0, 1, 2, 3};
        bus.c_11 = d0; bus.c_12 = d1; bus.c_21 = d2; bus.c_22 = d3;
        bus.col_major = cm;
        bus.in_valid  = 1'b1;
        for (int p = 0; p < 4; p++) begin
            e.data = arr[ord[p]];
            e.idx  = 2'(p);
            e.last = (p == 3);
            sb_q.push_back(e);
        end
        accepted = 0;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready) accepted = 1;
        end
        chk("load_accept_timeout", 32'(accepted), 32'd1);
        accept_cyc = cyc + 1;
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
        @(negedge clk);
        chk("first_out_valid", 32'(bus.out_valid), 32'd1);
        chk("first_out_data",  32'(bus.out_data),  32'(d0));
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && bus.in_ready) done = 1;
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfer0;
        bit seen;
        bus.in_valid = 0; bus.col_major = 0; bus.out_ready = 0;
        bus.c_11 = '0; bus.c_12 = '0; bus.c_21 = '0; bus.c_22 = '0;
        bus_w.in_valid = 0; bus_w.col_major = 0; bus_w.out_ready = 0;
        bus_w.c_11 = '0; bus_w.c_12 = '0; bus_w.c_21 = '0; bus_w.c_22 = '0;

        // Reset state.
        #22;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_mat_count", 32'(mat_count),     32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 1: row-major, no stall.
        bus.out_ready = 1'b1;
        load(17'd19, 17'd22, 17'd43, 17'd50, 1'b0, 0);
        wait_idle();
        chk("t1_span",      32'(last_xfer_cyc - accept_cyc), 32'd4);
        chk("t1_mat_count", 32'(mat_count),     32'd1);
        chk("t1_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_out_idx",   32'(bus.out_idx),   32'd0);

        // 2: column-major.
        @(posedge clk); #1;
        load(17'd19, 17'd22, 17'd43, 17'd50, 1'b1, 0);
        wait_idle();
        chk("t2_mat_count", 32'(mat_count), 32'd2);

        // 3: backpressure with input changes during SEND.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        load(17'h1FC02, 17'h1FC02, 17'h1FC02, 17'h1FC02, 1'b0, 0);
        bus.c_11 = '0; bus.c_12 = 17'h5; bus.c_21 = 17'hA; bus.c_22 = '1;
        bus.col_major = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                chk("t3_hold_data",  32'(bus.out_data),  32'h1FC02);
                chk("t3_hold_idx",   32'(bus.out_idx),   32'(k));
                chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            end
            @(posedge clk); #1 bus.out_ready = 1'b1;
            @(posedge clk); #1 bus.out_ready = 1'b0;
        end
        wait_idle();
        chk("t3_mat_count", 32'(mat_count), 32'd3);

        // 4: back-to-back sets with in_valid held.
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        load(17'd1, 17'd2, 17'd3, 17'd4, 1'b0, 1);
        load(17'd100, 17'd200, 17'd300, 17'd400, 1'b1, 0);
        chk("t4_reload_gap", 32'(accept_cyc - last_xfer_cyc), 32'd1);
        wait_idle();
        chk("t4_mat_count", 32'(mat_count), 32'd5);

        // 5: async reset after two transfers.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        load(17'd11, 17'd12, 17'd13, 17'd14, 1'b0, 0);
        xfer0 = n_xfer;
        @(posedge clk); #1 bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("t5_xfers", 32'(n_xfer - xfer0), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_mat_count", 32'(mat_count),     32'd0);
        chk("t5_rst_in_ready",  32'(bus.in_ready),  32'd1);
        sb_q.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        load(17'd7, 17'd8, 17'd9, 17'h1ABCD, 1'b0, 0);
        wait_idle();
        chk("t5_mat_count", 32'(mat_count), 32'd1);

        // 6: counter wrap on the 2-bit instance, element 0x7 first.
        bus_w.c_11 = 17'h00007; bus_w.c_12 = 17'd1; bus_w.c_21 = 17'd2; bus_w.c_22 = 17'd3;
        bus_w.out_ready = 1'b1;
        bus_w.in_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
`ifdef OUT_PARITY_EN
                if (bus_w.out_valid && bus_w.out_data == 17'h00007)
                    chk("t6_par", 32'(bus_w.out_par), 32'd1);
`endif
                if (bus_w.out_valid && bus_w.out_ready && bus_w.out_last) seen = 1;
            end
            chk("t6_last_timeout", 32'(seen), 32'd1);
            @(negedge clk);
            chk("t6_wrap_count", 32'(mat_count_w), 32'(k % 4));
        end
        bus_w.in_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
